// File: rtl/pwm_pkg.sv
// Shared duty-value constants, FSM state type and duty clamp helper for the
// PWM duty sequencer.
package pwm_pkg;

  localparam int unsigned DUTY_W = 4;
  localparam logic [DUTY_W-1:0] DUTY_MIN = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(9);
  localparam logic [DUTY_W-1:0] DUTY_RST = DUTY_W'(5);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] v);
    logic [DUTY_W-1:0] r;
    r = v;
    if (v < DUTY_MIN) r = DUTY_MIN;
    else if (v > DUTY_MAX) r = DUTY_MAX;
    return r;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Command/status bundle between a controller (master) and the duty sequencer
// (slave).
interface pwm_duty_sequencer_if;
  import pwm_pkg::*;

  logic              ena;
  logic              cmd_up;
  logic              cmd_down;
  logic              cmd_tgt_vld;
  logic [DUTY_W-1:0] cmd_tgt;
  logic              fade_en;
  logic              period_start;
  logic [DUTY_W-1:0] duty_out;
  logic              duty_load;
  logic              busy;
  logic              at_limit;

  modport master (
    output ena, cmd_up, cmd_down, cmd_tgt_vld, cmd_tgt, fade_en, period_start,
    input  duty_out, duty_load, busy, at_limit
  );

  modport slave (
    input  ena, cmd_up, cmd_down, cmd_tgt_vld, cmd_tgt, fade_en, period_start,
    output duty_out, duty_load, busy, at_limit
  );

endinterface

// File: rtl/pwm_step_timer.sv
// Counts PWM period starts modulo STEP_DIV and flags the period start that
// completes a ramp step interval.
module pwm_step_timer #(
  parameter int unsigned STEP_DIV = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  input  logic period_start_i,
  output logic step_tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_tick_o = en_i & period_start_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && period_start_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Owns the applied duty of one PWM channel: tracks a commanded target and
// ramps the applied duty toward it, changing it only on period boundaries.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned STEP_DIV = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pwm_duty_sequencer_if.slave  bus
);

  state_e            state_q;
  logic [DUTY_W-1:0] tgt_q, tgt_d;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] step_val;
  logic              load_q;
  logic              step_tick;

  pwm_step_timer #(
    .STEP_DIV(STEP_DIV),
    .CNT_W   (CNT_W)
  ) u_step_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (bus.ena && (state_q == RAMP)),
    .clr_i         (bus.ena && (state_q == IDLE)),
    .period_start_i(bus.period_start),
    .step_tick_o   (step_tick)
  );

  // Absolute load wins; simultaneous up/down cancel; saturate at the limits.
  always_comb begin
    tgt_d = tgt_q;
    if (bus.cmd_tgt_vld) begin
      tgt_d = clamp_duty(bus.cmd_tgt);
    end else if (bus.cmd_up ^ bus.cmd_down) begin
      if (bus.cmd_up) tgt_d = (tgt_q >= DUTY_MAX) ? DUTY_MAX : tgt_q + 1'b1;
      else            tgt_d = (tgt_q <= DUTY_MIN) ? DUTY_MIN : tgt_q - 1'b1;
    end
  end

  always_comb begin
    step_val = tgt_q;
    if (bus.fade_en) step_val = (tgt_q > duty_q) ? duty_q + 1'b1 : duty_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= DUTY_RST;
      duty_q  <= DUTY_RST;
      load_q  <= 1'b0;
    end else if (bus.ena) begin
      tgt_q  <= tgt_d;
      load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tgt_q != duty_q) state_q <= RAMP;
        end
        RAMP: begin
          // Target caught up with the applied duty: leave without a load.
          if (tgt_q == duty_q) begin
            state_q <= IDLE;
          end else if (step_tick) begin
            duty_q <= step_val;
            load_q <= 1'b1;
            if (step_val == tgt_q) state_q <= IDLE;
          end
        end
      endcase
    end else begin
      load_q <= 1'b0;
    end
  end

  assign bus.duty_out  = duty_q;
  assign bus.duty_load = load_q;
  assign bus.busy      = (state_q == RAMP);
  assign bus.at_limit  = (duty_q == DUTY_MIN) || (duty_q == DUTY_MAX);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Randomised bench with a period-level reference model and a load-event
// scoreboard for pwm_duty_sequencer.
module tb_pwm_duty_sequencer;

  localparam int STEP_DIV = 2;
  localparam int LO  = 1;
  localparam int HI  = 9;
  localparam int RST = 5;

  typedef struct {
    int duty;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_duty_sequencer_if bus ();

  pwm_duty_sequencer #(
    .STEP_DIV(STEP_DIV),
    .CNT_W   (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pcnt   = 0;
  exp_t exp_q[$];

  // Reference model: values the DUT should show after the next clock edge.
  int m_tgt  = RST;
  int m_duty = RST;
  int m_per  = 0;
  bit m_busy = 1'b0;

  bit g_en   = 1'b1;
  bit g_fade = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input bit rst, input bit en, input bit up, input bit dn,
                       input bit tv, input int tgt, input bit fade, input bit pst);
    int   nt;
    exp_t e;
    @(negedge clk);
    rst_n            = !rst;
    bus.ena          = en;
    bus.cmd_up       = up;
    bus.cmd_down     = dn;
    bus.cmd_tgt_vld  = tv;
    bus.cmd_tgt      = 4'(tgt);
    bus.fade_en      = fade;
    bus.period_start = pst;
    if (rst) begin
      m_tgt  = RST;
      m_duty = RST;
      m_busy = 1'b0;
      m_per  = 0;
    end else if (en) begin
      nt = m_tgt;
      if (tv)             nt = (tgt < LO) ? LO : (tgt > HI) ? HI : tgt;
      else if (up && !dn) nt = (m_tgt + 1 > HI) ? HI : m_tgt + 1;
      else if (dn && !up) nt = (m_tgt - 1 < LO) ? LO : m_tgt - 1;
      if (!m_busy) begin
        m_busy = (m_tgt != m_duty);
        m_per  = 0;
      end else if (m_tgt == m_duty) begin
        m_busy = 1'b0;
      end else if (pst) begin
        m_per++;
        if (m_per % STEP_DIV == 0) begin
          m_duty = fade ? (m_tgt > m_duty ? m_duty + 1 : m_duty - 1) : m_tgt;
          e.duty = m_duty;
          e.cyc  = cyc + 1;
          exp_q.push_back(e);
          if (m_duty == m_tgt) m_busy = 1'b0;
        end
      end
      m_tgt = nt;
    end
  endtask

  task automatic per(input bit up, input bit dn, input bit tv, input int tgt);
    pcnt = (pcnt + 1) % 10;
    drive(1'b0, g_en, up, dn, tv, tgt, g_fade, pcnt == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) per(1'b0, 1'b0, 1'b0, 0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    checks++;
    if (int'(bus.duty_out) != m_duty) begin
      errors++;
      $display("FAIL duty_out @%0d: got %0d expected %0d", cyc, bus.duty_out, m_duty);
    end
    checks++;
    if (bus.busy !== m_busy) begin
      errors++;
      $display("FAIL busy @%0d: got %b expected %b", cyc, bus.busy, m_busy);
    end
    checks++;
    if (bus.at_limit !== (m_duty == LO || m_duty == HI)) begin
      errors++;
      $display("FAIL at_limit @%0d: got %b for model duty %0d", cyc, bus.at_limit, m_duty);
    end
    if (bus.duty_load === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load @%0d: got load duty %0d expected no load", cyc, bus.duty_out);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.duty != int'(bus.duty_out)) begin
          errors++;
          $display("FAIL load @%0d: got duty %0d expected duty %0d at cycle %0d",
                   cyc, bus.duty_out, e.duty, e.cyc);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL missing_load @%0d: got no load expected duty %0d", cyc, e.duty);
    end
  end

  initial begin
    rst_n            = 1'b0;
    bus.ena          = 1'b1;
    bus.cmd_up       = 1'b0;
    bus.cmd_down     = 1'b0;
    bus.cmd_tgt_vld  = 1'b0;
    bus.cmd_tgt      = '0;
    bus.fade_en      = 1'b1;
    bus.period_start = 1'b0;

    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // 1: single up step, first load at the second period start
    g_fade = 1'b1;
    per(1'b1, 1'b0, 1'b0, 0);
    idle(40);
    // 2: fade to the top limit
    per(1'b0, 1'b0, 1'b1, 9);
    idle(100);
    // 3: saturation at the top, silent clamp of an oversize target
    for (int i = 0; i < 3; i++) begin
      per(1'b1, 1'b0, 1'b0, 0);
      idle(3);
    end
    per(1'b0, 1'b0, 1'b1, 15);
    idle(40);
    // 4: jump mode
    g_fade = 1'b0;
    per(1'b0, 1'b0, 1'b1, 2);
    idle(40);
    // 5: retarget mid-ramp, then cancelling up/down
    g_fade = 1'b1;
    per(1'b0, 1'b0, 1'b1, 8);
    for (int i = 0; i < 200 && m_duty != 4; i++) idle(1);
    per(1'b0, 1'b0, 1'b1, 3);
    per(1'b1, 1'b1, 1'b0, 0);
    idle(60);
    // 6: freeze mid-ramp, then reset mid-ramp
    per(1'b0, 1'b0, 1'b1, 9);
    idle(15);
    g_en = 1'b0;
    idle(55);
    g_en = 1'b1;
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, g_fade, 1'b1);
    idle(30);
    // boundary: lower clamp and lower saturation
    per(1'b0, 1'b0, 1'b1, 0);
    idle(120);
    per(1'b0, 1'b1, 1'b0, 0);
    idle(30);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) g_fade = !g_fade;
      drive($urandom_range(0, 599) == 0,
            $urandom_range(0, 15) != 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 49) == 0,
            int'($urandom_range(0, 15)),
            g_fade,
            $urandom_range(0, 3) == 0);
    end
    g_en = 1'b1;
    idle(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_loads: got %0d outstanding expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
